// File: rtl/chiplet_proto_pkg.sv
// Purpose: shared chiplet protocol definitions (command codes, packet field map, responder states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chiplet_proto_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_READ    = 3'b001,
        CMD_WRITE   = 3'b010,
        CMD_RD_RESP = 3'b101,
        CMD_WR_ACK  = 3'b110,
        CMD_ERR     = 3'b111
    } cmd_e;

    // Packet field map; everything above the data words is zero.
    localparam int CMD_LSB   = 0;
    localparam int CMD_W     = 3;
    localparam int TID_LSB   = 3;
    localparam int TID_W     = 6;
    localparam int DID_LSB   = 9;
    localparam int DID_W     = 6;
    localparam int LEN_LSB   = 15;
    localparam int LEN_W     = 3;
    localparam int ADDR_LSB  = 18;
    localparam int ADDR_W    = 32;
    localparam int DATA_LSB  = 50;
    localparam int WORD_W    = 32;
    localparam int MAX_BEATS = 8;

    // Word k of a burst sits at bits [32k +: 32].
    typedef logic [MAX_BEATS-1:0][WORD_W-1:0] data_arr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/chiplet_slave_responder_if.sv
// Purpose: bundles the responder's RX request fields, SRAM port and TX response port.
// Latency: n/a (wiring only).
// Backpressure: rx side via o_rx_ready, tx side via i_tx_ready.
// Modports: slave = responder side, master = environment (RX FSM, SRAM, TX FSM).
interface chiplet_slave_responder_if #(
    parameter int MEM_ADDR_W = 8,
    parameter int PKT_W      = 1076
);
    logic                  o_rx_ready;
    logic [2:0]            i_cmd;
    logic                  i_cmd_valid;
    logic [31:0]           i_addr;
    logic                  i_addr_valid;
    logic [5:0]            i_tid;
    logic                  i_tid_valid;
    logic [5:0]            i_did;
    logic                  i_did_valid;
    logic [2:0]            i_length;
    logic                  i_length_valid;
    logic [31:0]           i_data;
    logic                  i_data_valid;
    logic                  o_mem_en;
    logic                  o_mem_we;
    logic [MEM_ADDR_W-1:0] o_mem_addr;
    logic [31:0]           o_mem_wdata;
    logic [31:0]           i_mem_rdata;
    logic [PKT_W-1:0]      o_resp_pkt;
    logic                  o_resp_valid;
    logic                  i_tx_ready;

    modport slave (
        output o_rx_ready,
        input  i_cmd, i_cmd_valid, i_addr, i_addr_valid, i_tid, i_tid_valid,
        input  i_did, i_did_valid, i_length, i_length_valid, i_data, i_data_valid,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_resp_pkt, o_resp_valid,
        input  i_tx_ready
    );

    modport master (
        input  o_rx_ready,
        output i_cmd, i_cmd_valid, i_addr, i_addr_valid, i_tid, i_tid_valid,
        output i_did, i_did_valid, i_length, i_length_valid, i_data, i_data_valid,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_resp_pkt, o_resp_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/chiplet_slave_responder_resp_pkt_pack.sv
// Purpose: packs command/tid/did/length/addr and an 8-word buffer into a protocol packet.
// Latency: combinational.
// Backpressure: none.
// Ports: cmd, tid, did, len, addr, data in; pkt out (unused upper bits zero).
module resp_pkt_pack
    import chiplet_proto_pkg::*;
#(
    parameter int PKT_W = 1076
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [TID_W-1:0]  tid,
    input  logic [DID_W-1:0]  did,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] addr,
    input  data_arr_t         data,
    output logic [PKT_W-1:0]  pkt
);
    always_comb begin
        pkt = '0;
        pkt[CMD_LSB  +: CMD_W]              = cmd;
        pkt[TID_LSB  +: TID_W]              = tid;
        pkt[DID_LSB  +: DID_W]              = did;
        pkt[LEN_LSB  +: LEN_W]              = len;
        pkt[ADDR_LSB +: ADDR_W]             = addr;
        pkt[DATA_LSB +: MAX_BEATS * WORD_W] = data;
    end
endmodule

// File: rtl/chiplet_slave_responder.sv
// Purpose: slave responder; executes one READ/WRITE burst against local SRAM and builds the response packet.
// Latency: write resp 1 cycle after last data word; read resp length+3 cycles after entering RDATA.
// Backpressure: o_rx_ready low outside HDR/WDATA; response held stable until i_tx_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport: RX fields, SRAM port, TX packet).
module chiplet_slave_responder
    import chiplet_proto_pkg::*;
#(
    parameter int MEM_ADDR_W = 8,
    parameter int WORD_SIZE  = 32,
    parameter int PKT_W      = 1076
) (
    input logic                       clk,
    input logic                       rst_n,
    chiplet_slave_responder_if.slave  bus
);
    localparam int AW1 = MEM_ADDR_W + 1;

    state_e                state_q, state_d;
    logic [2:0]            cmd_q, len_q;
    logic [31:0]           addr_q;
    logic [5:0]            tid_q, did_q;
    logic                  have_cmd_q, have_addr_q, have_tid_q, have_did_q, have_len_q;
    cmd_e                  resp_cmd_q;
    logic [3:0]            beat_q;
    data_arr_t             buf_q;
    data_arr_t             pkt_data;
    logic [WORD_SIZE-1:0]  rdata;

    // Header view including this cycle's valids, so decode needs no extra cycle.
    logic [2:0]            cmd_m, len_m;
    logic [31:0]           addr_m;
    logic                  hdr_done;
    logic [MEM_ADDR_W-1:0] idx_m, idx_q;
    logic [AW1-1:0]        end_m;
    logic                  in_range_m;
    logic [3:0]            beat_m1;

    assign rdata   = bus.i_mem_rdata;
    assign cmd_m   = bus.i_cmd_valid    ? bus.i_cmd    : cmd_q;
    assign addr_m  = bus.i_addr_valid   ? bus.i_addr   : addr_q;
    assign len_m   = bus.i_length_valid ? bus.i_length : len_q;
    assign hdr_done = (state_q == ST_HDR)
                    && (have_cmd_q  || bus.i_cmd_valid)
                    && (have_addr_q || bus.i_addr_valid)
                    && (have_tid_q  || bus.i_tid_valid)
                    && (have_did_q  || bus.i_did_valid)
                    && (have_len_q  || bus.i_length_valid);

    // Last word index computed one bit wider so a burst past the top of SRAM cannot wrap.
    assign idx_m      = addr_m[MEM_ADDR_W+1:2];
    assign idx_q      = addr_q[MEM_ADDR_W+1:2];
    assign end_m      = {1'b0, idx_m} + AW1'(len_m);
    assign in_range_m = (addr_m[1:0] == 2'b00) && (addr_m[31:MEM_ADDR_W+2] == '0) && !end_m[MEM_ADDR_W];
    assign beat_m1    = beat_q - 4'd1;

    always_comb begin
        state_d          = state_q;
        bus.o_rx_ready   = 1'b0;
        bus.o_mem_en     = 1'b0;
        bus.o_mem_we     = 1'b0;
        bus.o_mem_addr   = '0;
        bus.o_mem_wdata  = '0;
        bus.o_resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_HDR;
            ST_HDR: begin
                bus.o_rx_ready = 1'b1;
                if (hdr_done) begin
                    if (cmd_m == CMD_READ && in_range_m) state_d = ST_RDATA;
                    else if (cmd_m == CMD_WRITE)         state_d = ST_WDATA;
                    else                                 state_d = ST_RESP;
                end
            end
            ST_WDATA: begin
                bus.o_rx_ready = 1'b1;
                if (bus.i_data_valid) begin
                    // A dropped write (ERR pending) still consumes its words.
                    if (resp_cmd_q != CMD_ERR) begin
                        bus.o_mem_en    = 1'b1;
                        bus.o_mem_we    = 1'b1;
                        bus.o_mem_addr  = idx_q + MEM_ADDR_W'(beat_q[2:0]);
                        bus.o_mem_wdata = bus.i_data;
                    end
                    if (beat_q[2:0] == len_q) state_d = ST_RESP;
                end
            end
            ST_RDATA: begin
                if (beat_q <= {1'b0, len_q}) begin
                    bus.o_mem_en   = 1'b1;
                    bus.o_mem_addr = idx_q + MEM_ADDR_W'(beat_q[2:0]);
                end
                if (beat_q == {1'b0, len_q} + 4'd2) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.o_resp_valid = 1'b1;
                if (bus.i_tx_ready) state_d = ST_HDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            tid_q       <= '0;
            did_q       <= '0;
            len_q       <= '0;
            have_cmd_q  <= 1'b0;
            have_addr_q <= 1'b0;
            have_tid_q  <= 1'b0;
            have_did_q  <= 1'b0;
            have_len_q  <= 1'b0;
            resp_cmd_q  <= CMD_NOP;
            beat_q      <= '0;
            buf_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_HDR: begin
                    if (bus.i_cmd_valid)    begin cmd_q  <= bus.i_cmd;    have_cmd_q  <= 1'b1; end
                    if (bus.i_addr_valid)   begin addr_q <= bus.i_addr;   have_addr_q <= 1'b1; end
                    if (bus.i_tid_valid)    begin tid_q  <= bus.i_tid;    have_tid_q  <= 1'b1; end
                    if (bus.i_did_valid)    begin did_q  <= bus.i_did;    have_did_q  <= 1'b1; end
                    if (bus.i_length_valid) begin len_q  <= bus.i_length; have_len_q  <= 1'b1; end
                    if (hdr_done) begin
                        beat_q <= '0;
                        if (cmd_m == CMD_READ && in_range_m)       resp_cmd_q <= CMD_RD_RESP;
                        else if (cmd_m == CMD_WRITE && in_range_m) resp_cmd_q <= CMD_WR_ACK;
                        else                                       resp_cmd_q <= CMD_ERR;
                    end
                end
                ST_WDATA: if (bus.i_data_valid) beat_q <= beat_q + 4'd1;
                ST_RDATA: begin
                    beat_q <= beat_q + 4'd1;
                    // SRAM data for the read issued at beat b arrives while beat_q == b+1.
                    if (beat_q != 4'd0 && beat_q <= {1'b0, len_q} + 4'd1)
                        buf_q[beat_m1[2:0]] <= rdata;
                end
                ST_RESP: if (bus.i_tx_ready) begin
                    have_cmd_q  <= 1'b0;
                    have_addr_q <= 1'b0;
                    have_tid_q  <= 1'b0;
                    have_did_q  <= 1'b0;
                    have_len_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Only slots actually read carry data; ERR/WR_ACK packets carry none.
    always_comb begin
        pkt_data = '0;
        for (int k = 0; k < MAX_BEATS; k++)
            if (resp_cmd_q == CMD_RD_RESP && 3'(k) <= len_q) pkt_data[k] = buf_q[k];
    end

    resp_pkt_pack #(.PKT_W(PKT_W)) u_pack (
        .cmd  (resp_cmd_q),
        .tid  (tid_q),
        .did  (did_q),
        .len  (len_q),
        .addr (addr_q),
        .data (pkt_data),
        .pkt  (bus.o_resp_pkt)
    );
endmodule

// File: doc/chiplet_slave_responder.md
Name: chiplet_slave_responder

Overview:
- Slave-side responder. Consumes decoded request fields from the slave RX FSM, executes the READ or WRITE against a local single-port synchronous SRAM, and builds a 1076-bit response packet for the slave TX FSM.
- Closes the request/response loop between master and slave chiplet.
- Handles one transaction at a time.

Parameters:
MEM_ADDR_W, 8, log2 of SRAM depth in 32-bit words
WORD_SIZE, 32, data word width (fixed at 32)
PKT_W, 1076, response packet width

Ports:
clk  input  1  clock (sole clock)
rst_n  input  1  asynchronous active-low reset
o_rx_ready  output  1  to RX FSM i_slave_rx_ready; high only in HDR and WDATA
i_cmd / i_cmd_valid  input  3/1  request command
i_addr / i_addr_valid  input  32/1  byte address, word-aligned
i_tid / i_tid_valid  input  6/1  transaction id
i_did / i_did_valid  input  6/1  destination id
i_length / i_length_valid  input  3/1  burst beats minus one (1..8 words)
i_data / i_data_valid  input  32/1  write data, one word per valid
o_mem_en  output  1  SRAM access enable
o_mem_we  output  1  SRAM write enable
o_mem_addr  output  MEM_ADDR_W  SRAM word index
o_mem_wdata  output  32  SRAM write data
i_mem_rdata  input  32  SRAM read data, valid 1 cycle after en&!we
o_resp_pkt  output  PKT_W  response packet to TX FSM i_protocol_bus
o_resp_valid  output  1  packet valid
i_tx_ready  input  1  TX FSM o_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0; captured fields and data buffer cleared. Reset mid-transaction abandons it and emits no response.
- Command encodings (package): NOP=000, READ=001, WRITE=010, RD_RESP=101, WR_ACK=110, ERR=111.
- Packet layout: [2:0] cmd, [8:3] tid, [14:9] did (the request tid/did echoed), [17:15] length, [49:18] addr, [305:50] data words 0..7 (word k at [50+32k +: 32]), [1075:306] zero. Unused data slots are zero.
- States:
  - IDLE → HDR unconditionally after reset.
  - HDR: o_rx_ready=1. Latch each field on its valid, in any order and possibly in the same cycle. Once cmd, addr, tid, did and length are all captured (including the capturing cycle's valids), decode:
    - READ and in range → RDATA.
    - WRITE and in range → WDATA.
    - WRITE and out of range or misaligned → WDATA with the drop flag set.
    - Anything else → RESP(ERR).
  - WDATA: o_rx_ready=1. Each i_data_valid writes the word to addr index + beat, same cycle (o_mem_en=o_mem_we=1). After length+1 words → RESP(WR_ACK), or RESP(ERR) if drop is set (no SRAM writes when dropping). i_data_valid seen in HDR is ignored.
  - RDATA: o_rx_ready=0. Issue length+1 consecutive reads, one per cycle. Capture i_mem_rdata one cycle later into buffer slot beat. Enter RESP the cycle after the last capture, i.e. length+3 cycles after entering RDATA.
  - RESP: o_resp_valid=1 and o_resp_pkt stable until i_tx_ready=1. Handshake cycle → HDR with all captured flags cleared. ERR and WR_ACK carry zero data.
- Range rule: index = addr[MEM_ADDR_W+1:2]. In range requires:
  - addr[1:0]==0, and
  - addr[31:MEM_ADDR_W+2]==0, and
  - index + length ≤ 2^MEM_ADDR_W − 1, computed MEM_ADDR_W+1 wide with no wrap-around.
- A field valid re-asserted before the header completes overwrites that field (last wins).
- o_mem_* are 0 outside active access cycles.

Decomposition:
- Package chiplet_proto_pkg holds:
  - cmd encodings;
  - packet field offsets/widths (CMD_LSB, TID_LSB, DID_LSB, LEN_LSB, ADDR_LSB, DATA_LSB, MAX_BEATS=8);
  - state enum.
- One sub-module, resp_pkt_pack: combinational packing of the fields plus the 8-word buffer into PKT_W bits. It is reusable by the master-side request builder.

Test Plan:
1. Write 3 words (cmd=010, addr=0x10, len=2, tid=5, did=3, data A,B,C) → SRAM idx 4,5,6 hold A,B,C; packet cmd=110, tid=5, did=3, addr=0x10, data=0.
2. Read back (cmd=001, addr=0x10, len=2) → o_rx_ready drops. Reads at idx 4,5,6 on consecutive cycles; o_resp_valid rises 5 cycles after RDATA entry; packet cmd=101, data[0..2]=A,B,C, word 3..7=0.
3. Out of range: WRITE addr=(2^MEM_ADDR_W−1)*4, len=1 with 2 data words → no SRAM writes; both words consumed; packet cmd=111, tid echoed.
4. Backpressure: hold i_tx_ready=0 for 10 cycles in RESP → o_resp_valid stays 1, packet bit-stable, o_rx_ready=0; release → one handshake, back to HDR.
5. Fields out of order and simultaneous: tid/did/cmd in one cycle, addr two cycles later, length last → decode occurs on the length cycle; a READ misaligned addr=0x2 → ERR.
6. Assert rst_n=0 in the middle of RDATA → all outputs 0 immediately (asynchronously); after release, no stale response; the next request is serviced normally.
